// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronizes channels A/B, decodes each
// prev->cur transition into a step pulse, direction and a wrapping
// N-bit position count with synchronous load.
// Optional feature macro: QUAD_DEC_ERR_EN enables the sticky err flag for
// illegal (double-change) transitions; without it err is tied to 0.
module quad_decoder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         ld,
    input  logic [N-1:0] din,
    output logic         step,
    output logic         dir,
    output logic [N-1:0] count,
    output logic         err
);

    // Warm-up sequencer: three edges after reset release before decoding
    typedef enum logic [1:0] {
        WARM0,
        WARM1,
        WARM2,
        RUN
    } state_t;

    state_t     state;
    logic       aSync1;
    logic       aSync2;
    logic       bSync1;
    logic       bSync2;
    logic [1:0] cur;
    logic [1:0] prev;
    logic       decodeEn;
    logic       fwd;
    logic       rev;

    // Two-flop synchronizers for the asynchronous encoder channels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aSync1 <= 1'b0;
            aSync2 <= 1'b0;
            bSync1 <= 1'b0;
            bSync2 <= 1'b0;
        end else begin
            aSync1 <= a_in;
            aSync2 <= aSync1;
            bSync1 <= b_in;
            bSync2 <= bSync1;
        end
    end

    assign cur      = {aSync2, bSync2};
    assign decodeEn = (state == RUN);

    // Classify prev->cur as forward (00,01,11,10 order) or reverse
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        case ({prev, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
            default: ;
        endcase
    end

    // Warm-up state, prev tracking and registered step/dir/count outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WARM0;
            prev  <= 2'b00;
            step  <= 1'b0;
            dir   <= 1'b0;
            count <= '0;
        end else begin
            prev <= cur;
            step <= 1'b0;
            case (state)
                WARM0:   state <= WARM1;
                WARM1:   state <= WARM2;
                WARM2:   state <= RUN;
                default: state <= RUN;
            endcase
            if (ld) begin
                count <= din;
            end else if (decodeEn && fwd) begin
                count <= count + N'(1);
                dir   <= 1'b1;
                step  <= 1'b1;
            end else if (decodeEn && rev) begin
                count <= count - N'(1);
                dir   <= 1'b0;
                step  <= 1'b1;
            end
        end
    end

`ifdef QUAD_DEC_ERR_EN
    logic illegal;

    assign illegal = ((prev ^ cur) == 2'b11);

    // Sticky illegal-transition flag; an illegal transition wins over a load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (decodeEn && illegal) begin
            err <= 1'b1;
        end else if (ld) begin
            err <= 1'b0;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Directed testbench for quad_decoder (N=8). Expected err follows
// QUAD_DEC_ERR_EN when the bench is compiled with the same macro set.
module tb_quad_decoder;

    localparam int N = 8;
`ifdef QUAD_DEC_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic         a_in;
    logic         b_in;
    logic         ld;
    logic [N-1:0] din;
    logic         step;
    logic         dir;
    logic [N-1:0] count;
    logic         err;

    int checks = 0;
    int errors = 0;

    quad_decoder #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .a_in  (a_in),
        .b_in  (b_in),
        .ld    (ld),
        .din   (din),
        .step  (step),
        .dir   (dir),
        .count (count),
        .err   (err)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic b);
        a_in = a;
        b_in = b;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic expStep, input logic expDir,
                            input logic [N-1:0] expCount, input logic expErr);
        checkOutput({tag, ".step"},  32'(step),  32'(expStep));
        checkOutput({tag, ".dir"},   32'(dir),   32'(expDir));
        checkOutput({tag, ".count"}, 32'(count), 32'(expCount));
        checkOutput({tag, ".err"},   32'(err),   32'(expErr));
    endtask

    logic [1:0] fwdSeq [4];
    logic [1:0] fwdSeq2 [3];

    // Directed sequence
    initial begin
        fwdSeq  = '{2'b01, 2'b11, 2'b10, 2'b00};
        fwdSeq2 = '{2'b10, 2'b00, 2'b01};
        reset = 1'b0;
        ld    = 1'b0;
        din   = '0;
        applyStimulus(1'b0, 1'b0);

        tick;
        tick;
        checkAll("reset", 1'b0, 1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        repeat (5) tick;
        checkAll("idle", 1'b0, 1'b0, 8'h00, 1'b0);

        // Four forward steps, update lands two edges after capture
        for (int i = 0; i < 4; i++) begin
            applyStimulus(fwdSeq[i][1], fwdSeq[i][0]);
            tick;
            tick;
            checkOutput("fwd.e1.step", 32'(step), 32'd0);
            tick;
            checkAll("fwd.e2", 1'b1, 1'b1, N'(i + 1), 1'b0);
            tick;
            checkOutput("fwd.e3.step", 32'(step), 32'd0);
        end

        // Load zero, then reverse wrap to all-ones
        ld  = 1'b1;
        din = 8'h00;
        tick;
        ld = 1'b0;
        checkAll("ld0", 1'b0, 1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (3) tick;
        checkAll("rev.wrap", 1'b1, 1'b0, 8'hFF, 1'b0);
        tick;
        checkOutput("rev.after.step", 32'(step), 32'd0);
        ld  = 1'b1;
        din = 8'hFF;
        tick;
        ld = 1'b0;
        checkAll("ldff", 1'b0, 1'b0, 8'hFF, 1'b0);
        applyStimulus(1'b0, 1'b0);
        repeat (3) tick;
        checkAll("fwd.wrap", 1'b1, 1'b1, 8'h00, 1'b0);
        tick;

        // Load coinciding with a legal forward decode
        applyStimulus(1'b0, 1'b1);
        tick;
        tick;
        ld  = 1'b1;
        din = 8'h5A;
        tick;
        ld = 1'b0;
        checkAll("ldcol", 1'b0, 1'b1, 8'h5A, 1'b0);
        tick;
        checkAll("ldcol.after", 1'b0, 1'b1, 8'h5A, 1'b0);

        applyStimulus(1'b0, 1'b0);
        repeat (3) tick;
        checkAll("rev2", 1'b1, 1'b0, 8'h59, 1'b0);
        tick;
        tick;

        // Illegal jump 00->11
        applyStimulus(1'b1, 1'b1);
        repeat (3) tick;
        checkAll("jump", 1'b0, 1'b0, 8'h59, ERR_EN);
        tick;
        checkAll("jump.hold", 1'b0, 1'b0, 8'h59, ERR_EN);
        ld  = 1'b1;
        din = 8'h10;
        tick;
        ld = 1'b0;
        checkAll("ldclr", 1'b0, 1'b0, 8'h10, 1'b0);

        // Reset with inputs held at 11 through release
        reset = 1'b0;
        #1;
        checkAll("rst2", 1'b0, 1'b0, 8'h00, 1'b0);
        tick;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            checkAll("warm", 1'b0, 1'b0, 8'h00, 1'b0);
        end

        // Count up to three, then assert reset between edges
        for (int i = 0; i < 3; i++) begin
            applyStimulus(fwdSeq2[i][1], fwdSeq2[i][0]);
            repeat (3) tick;
            checkAll("fwd3", 1'b1, 1'b1, N'(i + 1), 1'b0);
            tick;
        end
        #2;
        reset = 1'b0;
        #1;
        checkAll("async", 1'b0, 1'b0, 8'h00, 1'b0);
        tick;
        reset = 1'b1;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter N, default 8, meaning width of position count and load data.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port a_in  input  1  encoder channel A, asynchronous to clk.
REQ-005 SHALL have port b_in  input  1  encoder channel B, asynchronous to clk.
REQ-006 SHALL have port ld  input  1  synchronous load of count from din.
REQ-007 SHALL have port din  input  N  load value.
REQ-008 SHALL have port step  output  1  one-cycle pulse per legal quadrature transition.
REQ-009 SHALL have port dir  output  1  direction of last legal transition, 1 = forward.
REQ-010 SHALL have port count  output  N  signed-agnostic position count, registered.
REQ-011 SHALL have port err  output  1  sticky illegal-transition flag.

Function
REQ-012 SHALL pass a_in and b_in each through a two-flop synchronizer, giving cur = {a_s, b_s}.
REQ-013 SHALL hold a registered prev = {a, b} and decode the transition prev -> cur each cycle.
REQ-014 SHALL treat 00->01->11->10->00 as forward and the reverse order as reverse.
REQ-015 SHALL, for a forward transition, pulse step, set dir=1, and apply count+1 at the same edge.
REQ-016 SHALL, for a reverse transition, pulse step, set dir=0, and apply count-1 at the same edge.
REQ-017 SHALL, when prev == cur, leave step at 0 and count and dir unchanged.
REQ-018 SHALL treat double changes (00<->11, 01<->10) as illegal: no step, count and dir unchanged.
REQ-019 SHALL update prev <= cur every cycle, including illegal and load cycles.
REQ-020 SHALL have latency such that an input change captured by sync1 at edge E produces the step/count update at edge E+2.
REQ-021 SHALL wrap count modulo 2^N: all-ones +1 -> 0, and 0 -1 -> all-ones.
REQ-022 SHALL, when ld=1, set count <= din, suppress step, and leave dir unchanged, even if a legal transition coincides.
REQ-023 SHALL, when ld=1, clear err, unless an illegal transition occurs in the same cycle, in which case err=1.
REQ-024 SHALL sustain back-to-back legal transitions on consecutive cycles, each producing its own step.

Reset
REQ-025 SHALL, while reset=0, force count=0, step=0, dir=0, err=0, and synchronizers and prev=00.
REQ-026 SHALL, after reset deassertion, run a warm-up of 3 rising edges during which decoding is disabled and prev tracks cur.
REQ-027 SHALL resume decoding at the first cycle after warm-up, so static inputs at reset release never count or flag err.
REQ-028 SHALL return immediately to the REQ-025 values on reset assertion mid-operation, regardless of ld or transitions.

Configuration
REQ-029 SHALL use macro QUAD_DEC_ERR_EN to control illegal-transition reporting.
REQ-030 SHALL, with QUAD_DEC_ERR_EN defined, set err=1 on any illegal transition; err holds until ld or reset.
REQ-031 SHALL, without QUAD_DEC_ERR_EN, tie err to constant 0 with no err storage; illegal transitions still behave as in REQ-018.

Verification
REQ-032 SHALL cover: N=8, reset, 4 forward steps (00,01,11,10,00), each spaced 4 cycles -> 4 step pulses, dir=1, count=4, each update at E+2.
REQ-033 SHALL cover: count=0, one reverse transition 00->10 -> count=8'hFF, dir=0; then ld=1 with din=8'hFF, then one forward step -> count=8'h00.
REQ-034 SHALL cover: ld=1 with din=8'h5A in the same cycle a legal step decodes -> count=8'h5A, step=0.
REQ-035 SHALL cover: input jump 00->11 -> no step, count unchanged; err=1 with QUAD_DEC_ERR_EN, err=0 without; a later ld clears err.
REQ-036 SHALL cover: inputs held at 11 through reset release -> no step and err=0 after warm-up; reset asserted mid-sequence with count=3 -> all outputs 0 asynchronously.
